// File: rtl/noc_vc_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : noc_vc_buffer                                                |
// | Description : Router input buffer with one flit FIFO per virtual channel,  |
// |               a shared input flit bus, optional full-packet gating of      |
// |               out_valid with a full-FIFO overflow release, and per-channel |
// |               head-packet size reporting.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module noc_vc_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CHANNELS   = 2,
    parameter int FULLPACKET = 0,
    parameter int SW         = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FLIT_WIDTH-1:0]          in_flit,
    input  logic                           in_last,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    output logic [CHANNELS*FLIT_WIDTH-1:0] out_flit,
    output logic [CHANNELS-1:0]            out_last,
    output logic [CHANNELS-1:0]            out_valid,
    input  logic [CHANNELS-1:0]            out_ready,
    output logic [CHANNELS*SW-1:0]         packet_size
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [SW-1:0]      c_CNT_FULL  = SW'(DEPTH);
    localparam logic [SW-1:0]      c_CNT_ONE   = SW'(1);

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : (p + c_PTR_ONE);
    endfunction

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        // Flit storage holds {last, flit}; length storage holds whole-packet sizes.
        logic [FLIT_WIDTH:0] r_mem [DEPTH];
        logic [SW-1:0]       r_len [DEPTH];
        logic [c_PTR_W-1:0]  r_wp;
        logic [c_PTR_W-1:0]  r_rp;
        logic [c_PTR_W-1:0]  r_lwp;
        logic [c_PTR_W-1:0]  r_lrp;
        logic [SW-1:0]       r_cnt;
        logic [SW-1:0]       r_pkt;
        logic [SW-1:0]       r_acc;
        logic [SW-1:0]       r_hd;

        logic                w_in_ready;
        logic                w_in_fire;
        logic                w_in_tail;
        logic                w_out_valid;
        logic                w_out_fire;
        logic                w_out_tail;
        logic [FLIT_WIDTH:0] w_head;

        assign w_head     = r_mem[r_rp];
        assign w_in_ready = !rst && (r_cnt < c_CNT_FULL);
        assign w_in_fire  = in_valid[ch] && w_in_ready;
        assign w_in_tail  = w_in_fire && in_last;
        assign w_out_fire = w_out_valid && out_ready[ch];
        assign w_out_tail = w_out_fire && w_head[FLIT_WIDTH];

        if (FULLPACKET != 0) begin : g_fullpacket
            // Hold back until a whole packet is stored, unless the FIFO is full
            // (packet longer than DEPTH) or the head packet is already draining.
            assign w_out_valid = (r_cnt != '0) &&
                                 ((r_pkt != '0) || (r_cnt == c_CNT_FULL) || (r_hd != '0));
        end else begin : g_cut_through
            assign w_out_valid = (r_cnt != '0);
        end

        assign in_ready[ch]                         = w_in_ready;
        assign out_valid[ch]                        = w_out_valid;
        assign out_flit[ch*FLIT_WIDTH +: FLIT_WIDTH] = w_head[FLIT_WIDTH-1:0];
        assign out_last[ch]                         = w_head[FLIT_WIDTH];
        // Length fields and hd wrap modulo 2^SW; the difference stays exact
        // because the remaining count never exceeds DEPTH.
        assign packet_size[ch*SW +: SW]             = (r_pkt != '0) ? (r_len[r_lrp] - r_hd) : '0;

        // Storage writes: flit data and, on a tail, the completed packet length.
        always_ff @(posedge clk) begin
            if (w_in_fire) begin
                r_mem[r_wp] <= {in_last, in_flit};
            end
            if (w_in_tail) begin
                r_len[r_lwp] <= r_acc + c_CNT_ONE;
            end
        end

        // Pointers, occupancy, packet count and length accounting.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_lwp <= '0;
                r_lrp <= '0;
                r_cnt <= '0;
                r_pkt <= '0;
                r_acc <= '0;
                r_hd  <= '0;
            end else begin
                if (w_in_fire) begin
                    r_wp  <= f_ptr_inc(r_wp);
                    r_acc <= in_last ? '0 : (r_acc + c_CNT_ONE);
                end
                if (w_out_fire) begin
                    r_rp <= f_ptr_inc(r_rp);
                    r_hd <= w_head[FLIT_WIDTH] ? '0 : (r_hd + c_CNT_ONE);
                end
                if (w_in_tail) begin
                    r_lwp <= f_ptr_inc(r_lwp);
                end
                if (w_out_tail) begin
                    r_lrp <= f_ptr_inc(r_lrp);
                end
                case ({w_in_fire, w_out_fire})
                    2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
                    2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
                    default: r_cnt <= r_cnt;
                endcase
                case ({w_in_tail, w_out_tail})
                    2'b10:   r_pkt <= r_pkt + c_CNT_ONE;
                    2'b01:   r_pkt <= r_pkt - c_CNT_ONE;
                    default: r_pkt <= r_pkt;
                endcase
            end
        end
    end : g_ch

endmodule
`default_nettype wire

// File: doc/noc_vc_buffer.md
# noc_vc_buffer

Multi-channel successor to the single-queue NoC input buffer: one independent flit FIFO per virtual channel, sharing a common input flit bus. It sits at each router input port between the link and the route/arbitration stage. It adds per-channel full-packet gating with a deadlock-free overflow release, and per-channel head-packet size reporting.

## Interface
- `FLIT_WIDTH`, 32: flit payload width.
- `DEPTH`, 16: flits per channel FIFO; any value ≥ 2, not necessarily a power of two.
- `CHANNELS`, 2: number of virtual channels; ≥ 1.
- `FULLPACKET`, 0: nonzero enables full-packet gating of `out_valid`.
- `SW`, $clog2(DEPTH+1): derived width of `packet_size` fields.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `in_flit` in FLIT_WIDTH: flit shared by all channels.
- `in_last` in 1: flit is the tail of its packet.
- `in_valid` in CHANNELS: per-channel write request; at most one bit set per cycle.
- `in_ready` out CHANNELS: channel c can accept a flit.
- `out_flit` out CHANNELS*FLIT_WIDTH: head flit of channel c in slice [c*FLIT_WIDTH +: FLIT_WIDTH].
- `out_last` out CHANNELS: tail flag of the head flit.
- `out_valid` out CHANNELS: head flit of channel c is presentable.
- `out_ready` in CHANNELS: consumer takes the head flit of channel c.
- `packet_size` out CHANNELS*SW: flits remaining in channel c's head packet; slice [c*SW +: SW].

## Operation
- Per channel: circular storage of DEPTH entries of {last, flit}, with write pointer `wp`, read pointer `rp`, and occupancy `cnt` (0..DEPTH). Pointers wrap from DEPTH-1 to 0.
- Handshakes:
  - `in_ready[c]` = !rst && cnt < DEPTH.
  - `in_fire[c]` = in_valid[c] && in_ready[c].
  - `out_fire[c]` = out_valid[c] && out_ready[c].
  - `in_ready` does not depend on `out_ready`: there is no combinational in-to-out path.
- Occupancy update:
  - Push only: cnt+1.
  - Pop only: cnt-1.
  - Push and pop in the same cycle: cnt unchanged, both pointers advance.
- `pkt[c]` counts stored tail flits (0..DEPTH):
  - +1 on in_fire with in_last.
  - -1 on out_fire with out_last.
  - Both in the same cycle: unchanged.
- Length FIFO, per channel, DEPTH entries of SW bits:
  - Input accumulator `acc` counts flits of the packet currently being written.
  - On a tail in_fire, push acc+1 and clear acc.
  - Head counter `hd` counts flits already popped from the head packet. It clears on a tail out_fire.
- `packet_size[c]` = front length − hd when pkt>0, else 0.
- `out_valid[c]`:
  - FULLPACKET==0: cnt>0.
  - FULLPACKET!=0: cnt>0 && (pkt>0 || cnt==DEPTH || hd>0).
  - The cnt==DEPTH term releases packets longer than DEPTH.
  - The hd>0 term keeps a packet already started draining without further gating.
- `out_flit`/`out_last`: combinational read of storage at rp. Content is don't-care while out_valid is low.
- Multi-hot `in_valid` is illegal. The bench flags it with an assertion; RTL behaviour is unspecified.

## Timing
- Reset values:
  - cnt, pkt, acc, hd, wp, rp, and length FIFO pointers all 0.
  - out_valid = 0, packet_size = 0.
  - in_ready = 0 while rst is high; all 1 in the first cycle after rst deasserts.
- Latency: a flit pushed in cycle N appears at the head with out_valid in cycle N+1 (FULLPACKET==0, empty channel).
- FULLPACKET: out_valid rises the cycle after the tail flit is accepted.
- Full: in_ready drops the cycle after the DEPTH-th push. A pop in cycle N re-raises in_ready in N+1.
- Empty plus simultaneous push: no pop is possible, because out_valid is 0.
- Channels are fully independent: activity on one never stalls another.
- rst mid-packet: all stored flits and partial lengths are discarded.

## Test plan
- Reset, then push 1 flit (0xA, last) on ch0 with FULLPACKET=0 → out_valid[0]=1 next cycle, out_flit=0xA, out_last=1; ch1 stays out_valid=0.
- DEPTH=4: push 4 flits on ch1 with out_ready=0 → in_ready[1]=0 after the 4th push. Pop 1 → in_ready[1]=1 next cycle. Data order is preserved across the wrap.
- FULLPACKET=1: push a 3-flit packet on ch0 → out_valid stays 0 until the cycle after the tail; then packet_size=3, decrementing 3,2,1 on pops, and 0 after the tail pop.
- FULLPACKET=1, DEPTH=4: push 6 flits with no tail → once cnt=4, out_valid=1. Draining continues through the tail without deadlock, and all 6 flits emerge in order.
- Simultaneous push and pop on a half-full ch0 for 20 cycles → cnt constant, in_ready stays 1, output sequence equals the input sequence.
- Assert rst with 2 packets queued → next cycle out_valid=0, packet_size=0, in_ready=1 after release.
